// File: rtl/image_mem_arbiter.sv
// image_mem_arbiter
//   Shares one single-port synchronous image RAM between the display reader
//   and the filter engine. The display reader has absolute priority. The
//   filter uses a req/gnt handshake. The block also manages double buffering:
//   the display reads the front buffer, the filter writes the back buffer and
//   reads the fixed source image. Front and back swap on a frame boundary
//   once the filter has reported a completed pass.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   frame_start                 start-of-vblank pulse
//   disp_req/disp_ofs           display read request (never stalled)
//   disp_data/disp_valid        display read return, fixed latency 2
//   flt_req/we/ofs/wdata        filter request, held until flt_gnt
//   flt_gnt                     combinational grant
//   flt_rdata/flt_rvalid        filter read return, fixed latency 2
//   flt_done                    filter pass complete, requests a swap
//   swap_ack, front_sel         swap pulse, current front buffer
//   mem_addr/we/wdata/rdata     registered RAM interface
module image_mem_arbiter #(
    parameter int          OFS_W     = 12,
    parameter logic [18:0] SRC_BASE  = 19'h00028,
    parameter logic [18:0] BUF0_BASE = 19'h01028,
    parameter logic [18:0] BUF1_BASE = 19'h02028
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             disp_req,
    input  logic [OFS_W-1:0] disp_ofs,
    output logic [7:0]       disp_data,
    output logic             disp_valid,
    input  logic             flt_req,
    input  logic             flt_we,
    input  logic [OFS_W-1:0] flt_ofs,
    input  logic [7:0]       flt_wdata,
    output logic             flt_gnt,
    output logic [7:0]       flt_rdata,
    output logic             flt_rvalid,
    input  logic             flt_done,
    output logic             swap_ack,
    output logic             front_sel,
    output logic [18:0]      mem_addr,
    output logic             mem_we,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata
);

    typedef enum logic {ST_RUN = 1'b0, ST_SWAP_PEND = 1'b1} state_t;

    // Owner of a read travelling through the 2-stage return pipeline.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_FLT  = 2'd2
    } tag_t;

    state_t state_q, state_d;
    tag_t   tag1_q, tag1_d, tag2_q, tag2_d;

    logic [18:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  disp_data_q, disp_data_d;
    logic        disp_valid_q, disp_valid_d;
    logic [7:0]  flt_rdata_q, flt_rdata_d;
    logic        flt_rvalid_q, flt_rvalid_d;
    logic        swap_ack_q, swap_ack_d;
    logic        front_sel_q, front_sel_d;

    logic        swap_fire;
    logic [18:0] front_base, back_base;
    logic [18:0] disp_ofs_ext, flt_ofs_ext;

    assign front_base   = front_sel_q ? BUF1_BASE : BUF0_BASE;
    assign back_base    = front_sel_q ? BUF0_BASE : BUF1_BASE;
    assign disp_ofs_ext = {{(19-OFS_W){1'b0}}, disp_ofs};
    assign flt_ofs_ext  = {{(19-OFS_W){1'b0}}, flt_ofs};

    // ---------------- swap FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // ---------------- swap FSM: next state ----------------
    // A frame_start coinciding with flt_done in RUN does not swap; the swap
    // waits for the next frame boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:       if (flt_done)    state_d = ST_SWAP_PEND;
            ST_SWAP_PEND: if (frame_start) state_d = ST_RUN;
            default:                       state_d = ST_RUN;
        endcase
    end

    // ---------------- swap FSM: outputs ----------------
    // The filter is held off while a swap is pending so it cannot write into
    // a buffer that is about to become the front.
    always_comb begin
        flt_gnt   = flt_req & ~disp_req & (state_q == ST_RUN);
        swap_fire = (state_q == ST_SWAP_PEND) & frame_start;
    end

    // ---------------- address issue and return path ----------------
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        tag1_d      = TAG_NONE;

        if (disp_req) begin
            mem_addr_d = front_base + disp_ofs_ext;
            tag1_d     = TAG_DISP;
        end else if (flt_gnt) begin
            if (flt_we) begin
                mem_addr_d  = back_base + flt_ofs_ext;
                mem_we_d    = 1'b1;
                mem_wdata_d = flt_wdata;
            end else begin
                mem_addr_d = SRC_BASE + flt_ofs_ext;
                tag1_d     = TAG_FLT;
            end
        end

        // Stage 1 covers the RAM access cycle, stage 2 the capture of mem_rdata.
        tag2_d = tag1_q;

        disp_valid_d = (tag2_q == TAG_DISP);
        disp_data_d  = disp_valid_d ? mem_rdata : disp_data_q;
        flt_rvalid_d = (tag2_q == TAG_FLT);
        flt_rdata_d  = flt_rvalid_d ? mem_rdata : flt_rdata_q;

        front_sel_d = front_sel_q ^ swap_fire;
        swap_ack_d  = swap_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            tag1_q       <= TAG_NONE;
            tag2_q       <= TAG_NONE;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            flt_rdata_q  <= '0;
            flt_rvalid_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            front_sel_q  <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            flt_rdata_q  <= flt_rdata_d;
            flt_rvalid_q <= flt_rvalid_d;
            swap_ack_q   <= swap_ack_d;
            front_sel_q  <= front_sel_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign flt_rdata  = flt_rdata_q;
    assign flt_rvalid = flt_rvalid_q;
    assign swap_ack   = swap_ack_q;
    assign front_sel  = front_sel_q;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter with a behavioural synchronous RAM.
module tb_image_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        disp_req;
    logic [11:0] disp_ofs;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        flt_req;
    logic        flt_we;
    logic [11:0] flt_ofs;
    logic [7:0]  flt_wdata;
    logic        flt_gnt;
    logic [7:0]  flt_rdata;
    logic        flt_rvalid;
    logic        flt_done;
    logic        swap_ack;
    logic        front_sel;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [7:0] ram [0:16383];

    always #5 clk = ~clk;

    image_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .disp_req(disp_req), .disp_ofs(disp_ofs),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .flt_req(flt_req), .flt_we(flt_we), .flt_ofs(flt_ofs),
        .flt_wdata(flt_wdata), .flt_gnt(flt_gnt),
        .flt_rdata(flt_rdata), .flt_rvalid(flt_rvalid),
        .flt_done(flt_done), .swap_ack(swap_ack), .front_sel(front_sel),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port synchronous RAM, read data one cycle after address.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr[13:0]];
        if (mem_we) begin
            ram[mem_addr[13:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_start = 0; disp_req = 0; disp_ofs = 0;
        flt_req = 0; flt_we = 0; flt_ofs = 0; flt_wdata = 0; flt_done = 0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
        mem_rdata = 8'h00;
        for (int i = 0; i < 4; i++) ram[14'h1028 + i] = 8'h10 + 8'(i);
        ram[14'h1027] = 8'h5C;
        for (int i = 0; i < 4; i++) ram[14'h2028 + i] = 8'h80 + 8'(i);

        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr",   mem_addr, 0);
        chk("rst_mem_we",     mem_we, 0);
        chk("rst_mem_wdata",  mem_wdata, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_data",  disp_data, 0);
        chk("rst_flt_rvalid", flt_rvalid, 0);
        chk("rst_swap_ack",   swap_ack, 0);
        chk("rst_front_sel",  front_sel, 0);
        rst_n = 1;
        tick();

        // Display stream ofs 0..3 from BUF0, latency 2.
        for (int j = 0; j < 7; j++) begin
            disp_req = (j < 4);
            disp_ofs = 12'(j);
            tick();
            if (j < 4) chk("d_addr", mem_addr, 32'h1028 + j);
            chk("d_valid", disp_valid, (j >= 2 && j < 6));
            if (j >= 2 && j < 6) chk("d_data", disp_data, 32'h10 + j - 2);
        end
        idle_inputs();

        // Filter write ofs 5 into back buffer (BUF1).
        flt_req = 1; flt_we = 1; flt_ofs = 12'd5; flt_wdata = 8'hAA;
        #2 chk("w_gnt", flt_gnt, 1);
        tick();
        chk("w_addr",  mem_addr, 32'h0202D);
        chk("w_we",    mem_we, 1);
        chk("w_wdata", mem_wdata, 8'hAA);
        idle_inputs();
        tick();
        chk("w_we_drop", mem_we, 0);
        chk("w_ram", ram[14'h202D], 8'hAA);

        // Filter held off by 3 display cycles; exactly one write.
        wr_cnt = 0;
        flt_we = 1; flt_ofs = 12'd7; flt_wdata = 8'h55;
        for (int j = 0; j < 6; j++) begin
            flt_req  = (j <= 3);
            disp_req = (j < 3);
            disp_ofs = 12'(j);
            #2 chk("h_gnt", flt_gnt, (j == 3));
            tick();
            chk("h_we", mem_we, (j == 3));
            if (j < 3)  chk("h_daddr", mem_addr, 32'h1028 + j);
            if (j == 3) chk("h_waddr", mem_addr, 32'h0202F);
            chk("h_dvalid", disp_valid, (j >= 2 && j < 5));
            if (j >= 2 && j < 5) chk("h_ddata", disp_data, 32'h10 + j - 2);
        end
        idle_inputs();
        tick();
        chk("h_wr_cnt", wr_cnt, 1);

        // Filter read ofs 0xFFF wraps into SRC region: 0x28 + 0xFFF = 0x1027.
        flt_req = 1; flt_we = 0; flt_ofs = 12'hFFF;
        #2 chk("r_gnt", flt_gnt, 1);
        tick();
        idle_inputs();
        chk("r_addr", mem_addr, 32'h01027);
        chk("r_we",   mem_we, 0);
        tick();
        chk("r_rvalid_early", flt_rvalid, 0);
        tick();
        chk("r_rvalid", flt_rvalid, 1);
        chk("r_rdata",  flt_rdata, 8'h5C);
        chk("r_dvalid", disp_valid, 0);
        tick();
        chk("r_rvalid_drop", flt_rvalid, 0);
        chk("r_rdata_hold",  flt_rdata, 8'h5C);

        // flt_done with frame_start in the same RUN cycle: no swap yet.
        flt_done = 1; frame_start = 1;
        tick();
        idle_inputs();
        chk("s_noswap_ack", swap_ack, 0);
        chk("s_noswap_sel", front_sel, 0);
        // Pending: filter held off for 5 cycles, extra flt_done ignored.
        flt_req = 1; flt_we = 1; flt_ofs = 12'd9; flt_wdata = 8'h33;
        for (int j = 0; j < 5; j++) begin
            flt_done = (j == 1);
            #2 chk("s_gnt", flt_gnt, 0);
            tick();
            chk("s_we", mem_we, 0);
            chk("s_ack_low", swap_ack, 0);
        end
        flt_done = 0;
        frame_start = 1;
        #2 chk("s_gnt_fs", flt_gnt, 0);
        tick();
        frame_start = 0; flt_req = 0;
        chk("s_ack", swap_ack, 1);
        chk("s_sel", front_sel, 1);
        disp_req = 1; disp_ofs = 0;
        tick();
        chk("s_ack_pulse", swap_ack, 0);
        chk("s_new_front", mem_addr, 32'h02028);
        disp_ofs = 1;
        tick();
        disp_req = 0;
        // Two display reads in flight; async reset mid-stream.
        #2 rst_n = 0;
        #1;
        chk("x_dvalid",  disp_valid, 0);
        chk("x_rvalid",  flt_rvalid, 0);
        chk("x_sel",     front_sel, 0);
        chk("x_addr",    mem_addr, 0);
        @(negedge clk);
        rst_n = 1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("x_no_valid", disp_valid, 0);
        end
        disp_req = 1; disp_ofs = 12'd1;
        tick();
        disp_req = 0;
        chk("x_addr_buf0", mem_addr, 32'h01029);
        tick();
        chk("x_valid_early", disp_valid, 0);
        tick();
        chk("x_valid", disp_valid, 1);
        chk("x_data",  disp_data, 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
